muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Multi-cycle controller for RV32M multiply/divide operations, which the single-cycle ALU of the execute stage does not handle.
- Accepts one operation at a time from the execute stage and runs an iterative shift-add multiplier or a restoring divider, one bit per cycle.
- Drives stall_flg so the execute stage holds its instruction until the result is ready.
- Sits beside the execute-stage ALU; its result is muxed into alu_out by the execute stage.

Parameters:
- XLEN, 32, operand/result width; iteration count equals XLEN.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request; sampled only in IDLE.
- funct  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op1_data  in  XLEN  rs1 value (dividend / multiplicand).
- op2_data  in  XLEN  rs2 value (divisor / multiplier).
- flush  in  1  abort the current operation (branch/trap redirect).
- stall_flg  out  1  high while the request cannot complete this cycle.
- busy  out  1  state is MUL or DIV.
- result_valid  out  1  one-cycle pulse, result ready.
- result  out  XLEN  final value; held until the next accepted start.

Behaviour:
- Reset is asynchronous, active-low. On reset: state=IDLE, counter=0, result=0, result_valid=0, busy=0, internal operand registers=0.
- States: IDLE, MUL, DIV, DONE.
- IDLE with start=1 and flush=0 (cycle T):
  - Latch funct.
  - Latch absolute values of signed operands: op1 for MULH/MULHSU/DIV/REM, op2 for MULH/DIV/REM.
  - Record the result sign:
    - MUL-type: XOR of the operand signs that are treated as signed.
    - Quotient: sign(op1) XOR sign(op2).
    - Remainder: sign(op1).
  - Next state:
    - funct<4: MUL.
    - Divisor zero: DONE, with quotient=all ones and remainder=op1.
    - Signed overflow (op1=0x80000000, op2=0xFFFFFFFF, DIV/REM): DONE, with quotient=0x80000000 and remainder=0.
    - Otherwise: DIV.
- MUL/DIV:
  - The 5-bit counter steps 0..XLEN-1, one iteration per cycle (T+1..T+XLEN).
  - When counter=XLEN-1, apply the sign fix and select the output:
    - MUL: low word of the 2*XLEN product.
    - MULH/MULHSU/MULHU: high word.
    - DIV/DIVU: quotient.
    - REM/REMU: remainder.
  - Write result and go to DONE.
- DONE (T+XLEN+1 normally, T+1 for special cases):
  - result_valid=1 for exactly one cycle.
  - Next state is IDLE.
  - start is ignored in DONE.
- stall_flg = (IDLE & start & ~flush) | busy. It is low in DONE, so the execute stage consumes result that cycle.
- Normal latency: start at T, result_valid at T+33, stall_flg high T..T+32.
- Special-case latency: result_valid at T+1, stall_flg high only at T.
- Signed MUL sign fix: two's-complement negation of the full 2*XLEN product before the word select.
- flush in any state:
  - Next state is IDLE and the counter is cleared.
  - No result_valid and result is unchanged.
  - flush overrides a simultaneous start.
- Operand inputs are don't-care after acceptance; internal copies are used.
- rst_n asserted mid-operation: immediate return to IDLE, no result_valid after deassert.

Decomposition:
- Shared core package:
  - funct encodings MD_MUL..MD_REMU.
  - State encoding (2 bits): IDLE=0, MUL=1, DIV=2, DONE=3.
  - Constants XLEN_MIN_SIGNED=0x80000000 and ALL_ONES.
- One sub-module, muldiv_step: combinational single-iteration datapath.
  - Multiply: shift-add of the partial product.
  - Divide: restoring subtract/shift on the remainder/quotient pair.
  - Selected by a mode bit.
- The sequencer owns the FSM, counter, sign fix and output register.

Test Plan:
- MUL 7 * 6 at T → stall_flg high T..T+32, result_valid at T+33, result=0x0000002A.
- MULH 0xFFFFFFFF * 0xFFFFFFFF → 0x00000000; MULHU same operands → 0xFFFFFFFE; MULHSU 0xFFFFFFFF, 0x00000002 → 0xFFFFFFFF.
- DIV -7/2 → 0xFFFFFFFD; REM -7/2 → 0xFFFFFFFF; DIVU 100/7 → 0x0000000E; REMU 100/7 → 0x00000002; each valid at T+33.
- DIV 5/0 → 0xFFFFFFFF and REM 5/0 → 0x00000005, valid at T+1; DIV 0x80000000/0xFFFFFFFF → 0x80000000 and REM → 0, valid at T+1.
- DIVU 100/7 started, flush at T+10 → IDLE at T+11, no result_valid, result keeps its prior value; start at T+11 is accepted normally.
- rst_n pulsed low at T+5 of a MUL → all outputs 0 immediately; start+flush together in IDLE → stays IDLE, stall_flg=0.

Source files
------------

// File: rtl/muldiv_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer_pkg
// Description : Shared encodings and constants for the RV32M multiply/divide
//               sequencer and its single-iteration datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_sequencer_pkg;

    // RV32M funct3 encodings
    localparam logic [2:0] MD_MUL    = 3'd0;
    localparam logic [2:0] MD_MULH   = 3'd1;
    localparam logic [2:0] MD_MULHSU = 3'd2;
    localparam logic [2:0] MD_MULHU  = 3'd3;
    localparam logic [2:0] MD_DIV    = 3'd4;
    localparam logic [2:0] MD_DIVU   = 3'd5;
    localparam logic [2:0] MD_REM    = 3'd6;
    localparam logic [2:0] MD_REMU   = 3'd7;

    // Sequencer state encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MUL  = 2'd1;
    localparam logic [1:0] ST_DIV  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    localparam logic [31:0] XLEN_MIN_SIGNED = 32'h8000_0000;
    localparam logic [31:0] ALL_ONES        = 32'hFFFF_FFFF;

    // REM/REMU select the remainder, DIV/DIVU the quotient
    function automatic logic is_rem(input logic [2:0] f);
        return f[2] & f[1];
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_sequencer_step.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_step
// Description : One iteration of the shift-add multiplier or the restoring
//               divider. {hi,lo} is the product pair (multiply) or the
//               remainder/quotient pair (divide); opb is the multiplicand or
//               divisor.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int XLEN = 32
) (
    input  logic            mode_div,
    input  logic [XLEN-1:0] hi_in,
    input  logic [XLEN-1:0] lo_in,
    input  logic [XLEN-1:0] opb,
    output logic [XLEN-1:0] hi_out,
    output logic [XLEN-1:0] lo_out
);

    logic [XLEN:0] w_sum;
    logic [XLEN:0] w_trial;
    logic          w_ge;

    // Single iteration: add-then-shift-right, or shift-left-then-trial-subtract
    always_comb begin
        w_sum   = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opb} : '0);
        w_trial = {hi_in, lo_in[XLEN-1]};
        w_ge    = (w_trial >= {1'b0, opb});
        if (mode_div) begin
            // The restored remainder is always below the divisor, so the
            // low XLEN bits of the difference hold it exactly.
            hi_out = w_ge ? (w_trial[XLEN-1:0] - opb) : w_trial[XLEN-1:0];
            lo_out = {lo_in[XLEN-2:0], w_ge};
        end else begin
            hi_out = w_sum[XLEN:1];
            lo_out = {w_sum[0], lo_in[XLEN-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_sequencer
// Description : Multi-cycle RV32M multiply/divide controller. Runs one bit
//               per cycle through muldiv_step, applies the result sign fix
//               and holds the result for the execute stage.
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_sequencer
    import muldiv_sequencer_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [2:0]      funct,
    input  logic [XLEN-1:0] op1_data,
    input  logic [XLEN-1:0] op2_data,
    input  logic            flush,
    output logic            stall_flg,
    output logic            busy,
    output logic            result_valid,
    output logic [XLEN-1:0] result
);

    localparam int            CW       = $clog2(XLEN);
    localparam logic [CW-1:0] CNT_LAST = CW'(XLEN - 1);

    logic [1:0]      state_q,  state_d;
    logic [CW-1:0]   cnt_q,    cnt_d;
    logic [2:0]      funct_q,  funct_d;
    logic [XLEN-1:0] hi_q,     hi_d;
    logic [XLEN-1:0] lo_q,     lo_d;
    logic [XLEN-1:0] opb_q,    opb_d;
    logic            neg_q,    neg_d;
    logic [XLEN-1:0] result_q, result_d;

    logic              w_accept;
    logic              w_op1_signed, w_op2_signed;
    logic              w_s1, w_s2;
    logic [XLEN-1:0]   w_abs1, w_abs2;
    logic              w_neg_start;
    logic              w_div_zero, w_overflow;
    logic [XLEN-1:0]   w_hi_step, w_lo_step;
    logic [2*XLEN-1:0] w_prod_fix;
    logic [XLEN-1:0]   w_quo_fix, w_rem_fix, w_final;

    // Operand decode for the accepting cycle: absolute values and result sign
    always_comb begin
        w_accept     = (state_q == ST_IDLE) & start & ~flush;
        w_op1_signed = (funct == MD_MULH) | (funct == MD_MULHSU) |
                       (funct == MD_DIV)  | (funct == MD_REM);
        w_op2_signed = (funct == MD_MULH) | (funct == MD_DIV) | (funct == MD_REM);
        w_s1         = w_op1_signed & op1_data[XLEN-1];
        w_s2         = w_op2_signed & op2_data[XLEN-1];
        w_abs1       = w_s1 ? ('0 - op1_data) : op1_data;
        w_abs2       = w_s2 ? ('0 - op2_data) : op2_data;
        // Remainder takes the dividend sign; everything else is the XOR
        w_neg_start  = (funct == MD_REM) ? w_s1 : (w_s1 ^ w_s2);
        w_div_zero   = (op2_data == '0);
        w_overflow   = ((funct == MD_DIV) | (funct == MD_REM)) &
                       (op1_data == XLEN_MIN_SIGNED) & (op2_data == ALL_ONES);
    end

    muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .mode_div (state_q == ST_DIV),
        .hi_in    (hi_q),
        .lo_in    (lo_q),
        .opb      (opb_q),
        .hi_out   (w_hi_step),
        .lo_out   (w_lo_step)
    );

    // Sign fix on the final iteration's output and word select by funct
    always_comb begin
        w_prod_fix = neg_q ? ('0 - {w_hi_step, w_lo_step}) : {w_hi_step, w_lo_step};
        w_quo_fix  = neg_q ? ('0 - w_lo_step) : w_lo_step;
        w_rem_fix  = neg_q ? ('0 - w_hi_step) : w_hi_step;
        case (funct_q)
            MD_MUL:                      w_final = w_prod_fix[XLEN-1:0];
            MD_MULH, MD_MULHSU, MD_MULHU: w_final = w_prod_fix[2*XLEN-1:XLEN];
            MD_DIV, MD_DIVU:             w_final = w_quo_fix;
            default:                     w_final = w_rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; flush wins over everything, including a new start
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        if (!funct[2])                     state_d = ST_MUL;
                        else if (w_div_zero || w_overflow) state_d = ST_DONE;
                        else                               state_d = ST_DIV;
                    end
                end
                ST_MUL, ST_DIV: begin
                    if (cnt_q == CNT_LAST) state_d = ST_DONE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Outputs; a flush in DONE suppresses the pulse
    always_comb begin
        busy         = (state_q == ST_MUL) | (state_q == ST_DIV);
        result_valid = (state_q == ST_DONE) & ~flush;
        stall_flg    = w_accept | busy;
        result       = result_q;
    end

    // Datapath next values: operand capture, iteration, result write
    always_comb begin
        cnt_d    = cnt_q;
        funct_d  = funct_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        opb_d    = opb_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (flush) begin
            cnt_d = '0;
        end else if (w_accept) begin
            funct_d = funct;
            neg_d   = w_neg_start;
            hi_d    = '0;
            cnt_d   = '0;
            // Multiply: lo = multiplier, opb = multiplicand.
            // Divide:   lo = dividend,   opb = divisor.
            lo_d    = funct[2] ? w_abs1 : w_abs2;
            opb_d   = funct[2] ? w_abs2 : w_abs1;
            if (funct[2] && w_div_zero) begin
                result_d = is_rem(funct) ? op1_data : ALL_ONES;
            end else if (w_overflow) begin
                result_d = is_rem(funct) ? '0 : XLEN_MIN_SIGNED;
            end
        end else if (busy) begin
            hi_d = w_hi_step;
            lo_d = w_lo_step;
            if (cnt_q == CNT_LAST) begin
                cnt_d    = '0;
                result_d = w_final;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q    <= '0;
            funct_q  <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            opb_q    <= '0;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            cnt_q    <= cnt_d;
            funct_q  <= funct_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            opb_q    <= opb_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

endmodule
`default_nettype wire
